// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared encodings and decode helpers for the data SRAM access controller
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_DISCARD = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef struct packed {
        logic [1:0] size;
        logic       bad;
    } wen_dec_t;

    // Store size comes from the byte-enable pattern; anything irregular is rejected.
    function automatic wen_dec_t wen_decode(input logic [3:0] wen);
        wen_dec_t d;
        d.size = SZ_B;
        d.bad  = 1'b0;
        case (wen)
            4'b1111:                            d.size = SZ_W;
            4'b0011, 4'b1100:                   d.size = SZ_H;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: d.size = SZ_B;
            default:                            d.bad  = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return |addr_lo;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_req_check.sv
// rtl/mem_req_check.sv - combinational size/strobe derivation and alignment check for one request
module mem_req_check
    import mem_access_ctrl_pkg::*;
(
    input  logic [3:0] i_wen,
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic [1:0] o_size,
    output logic [3:0] o_wstrb,
    output logic       o_misaligned
);

    wen_dec_t w_dec;

    assign w_dec = wen_decode(i_wen);

    always_comb begin
        o_size       = i_size;
        o_wstrb      = 4'b0000;
        o_misaligned = is_misaligned(i_size, i_addr_lo);
        if (|i_wen) begin
            o_size       = w_dec.size;
            o_wstrb      = i_wen;
            o_misaligned = w_dec.bad | is_misaligned(w_dec.size, i_addr_lo);
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage sequencer for the req/addr_ok/data_ok data SRAM handshake
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall_hold,
    input  logic              req_valid,
    input  logic [3:0]        req_wen,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [3:0]        data_sram_wstrb,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    output logic              stallreq_for_mem,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata_out,
    output logic              addr_err,
    output logic              timeout_err
);

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [3:0]        r_wstrb;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [7:0]        r_cnt;
    logic              r_addr_err;
    logic              r_timeout;

    logic [1:0]        w_size;
    logic [3:0]        w_wstrb;
    logic              w_misaligned;
    logic              w_idle_req;
    logic              w_accept;
    logic              w_waiting;
    logic              w_wd_fire;
    logic              w_wd_abort;

    mem_req_check u_req_check (
        .i_wen        (req_wen),
        .i_size       (req_size),
        .i_addr_lo    (req_addr[1:0]),
        .o_size       (w_size),
        .o_wstrb      (w_wstrb),
        .o_misaligned (w_misaligned)
    );

    assign w_idle_req = (r_state == ST_IDLE) & req_valid & ~flush;
    assign w_accept   = w_idle_req & ~w_misaligned;
    assign w_waiting  = (r_state == ST_ADDR) | (r_state == ST_DATA) | (r_state == ST_DISCARD);
    assign w_wd_fire  = w_waiting & (r_cnt == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // A real handshake event in the same cycle always wins over the watchdog,
    // so an accepted address is never abandoned with a response outstanding.
    always_comb begin
        w_state_nxt = r_state;
        w_wd_abort  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                if (data_sram_addr_ok) w_state_nxt = flush ? ST_DISCARD : ST_DATA;
                else if (flush)        w_state_nxt = ST_IDLE;
                else if (w_wd_fire) begin
                    w_state_nxt = ST_IDLE;
                    w_wd_abort  = 1'b1;
                end
            end
            ST_DATA: begin
                if (flush)                  w_state_nxt = data_sram_data_ok ? ST_IDLE : ST_DISCARD;
                else if (data_sram_data_ok) w_state_nxt = ST_DONE;
                else if (w_wd_fire) begin
                    w_state_nxt = ST_IDLE;
                    w_wd_abort  = 1'b1;
                end
            end
            ST_DISCARD: begin
                if (data_sram_data_ok) w_state_nxt = ST_IDLE;
                else if (w_wd_fire) begin
                    w_state_nxt = ST_IDLE;
                    w_wd_abort  = 1'b1;
                end
            end
            ST_DONE: begin
                if (!(stall_hold && !flush)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        data_sram_req    = 1'b0;
        rdata_valid      = 1'b0;
        stallreq_for_mem = 1'b0;
        case (r_state)
            ST_IDLE:    stallreq_for_mem = w_accept;
            ST_ADDR: begin
                data_sram_req    = 1'b1;
                stallreq_for_mem = 1'b1;
            end
            ST_DATA:    stallreq_for_mem = 1'b1;
            ST_DISCARD: stallreq_for_mem = req_valid;
            ST_DONE:    rdata_valid      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr       <= 1'b0;
            r_size     <= 2'd0;
            r_wstrb    <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= 8'd0;
            r_addr_err <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr    <= |req_wen;
                r_size  <= w_size;
                r_wstrb <= w_wstrb;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == ST_DATA && data_sram_data_ok && !flush)
                r_rdata <= r_wr ? '0 : data_sram_rdata;
            r_addr_err <= w_idle_req & w_misaligned;
            if (w_state_nxt != r_state || !w_waiting) r_cnt <= 8'd0;
            else                                      r_cnt <= r_cnt + 8'd1;
            if (w_wd_abort) r_timeout <= 1'b1;
        end
    end

    assign data_sram_wr    = r_wr;
    assign data_sram_size  = r_size;
    assign data_sram_wstrb = r_wstrb;
    assign data_sram_addr  = r_addr;
    assign data_sram_wdata = r_wdata;
    assign rdata_out       = r_rdata;
    assign addr_err        = r_addr_err;
    assign timeout_err     = r_timeout;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0, stall_hold = 1'b0, req_valid = 1'b0;
    logic [3:0]  req_wen = 4'd0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok = 1'b0, data_sram_data_ok = 1'b0;
    logic [31:0] data_sram_rdata = 32'd0;
    logic        stallreq_for_mem, rdata_valid, addr_err, timeout_err;
    logic [31:0] rdata_out;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_hold(stall_hold),
        .req_valid(req_valid), .req_wen(req_wen), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .stallreq_for_mem(stallreq_for_mem),
        .rdata_valid(rdata_valid), .rdata_out(rdata_out),
        .addr_err(addr_err), .timeout_err(timeout_err)
    );

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } obs_t;

    typedef struct {
        int          kind;   // 0 = completed access, 1 = addr_err pulse
        logic [31:0] data;
    } exp_t;

    obs_t obs_q[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    bit   finished = 1'b0;
    logic prev_rv = 1'b0;
    int   n_req;

    task automatic obs(input string n, input logic [31:0] a, input logic [31:0] e);
        obs_t o;
        o.name = n; o.act = a; o.exp = e;
        obs_q.push_back(o);
    endtask

    task automatic expect_ev(input int k, input logic [31:0] d);
        exp_t e;
        e.kind = k; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_wen = w; req_size = s; req_addr = a; req_wdata = d;
    endtask

    // Minimum-latency word load; returns sampled in the first DONE cycle.
    task automatic do_load(input logic [31:0] a, input logic [31:0] d, input string tag);
        expect_ev(0, d);
        issue(4'b0000, 2'd2, a, 32'd0);
        smp; obs({tag, "_stall_c0"}, 32'(stallreq_for_mem), 32'd1);
        tick; req_valid = 1'b0; data_sram_addr_ok = 1'b1;
        smp; obs({tag, "_req_c1"}, 32'(data_sram_req), 32'd1);
        obs({tag, "_addr_c1"}, data_sram_addr, a);
        obs({tag, "_size_c1"}, 32'(data_sram_size), 32'd2);
        obs({tag, "_stall_c1"}, 32'(stallreq_for_mem), 32'd1);
        tick; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = d;
        smp; obs({tag, "_req_c2"}, 32'(data_sram_req), 32'd0);
        obs({tag, "_stall_c2"}, 32'(stallreq_for_mem), 32'd1);
        tick; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
        smp; obs({tag, "_rvalid_c3"}, 32'(rdata_valid), 32'd1);
        obs({tag, "_stall_c3"}, 32'(stallreq_for_mem), 32'd0);
    endtask

    initial begin : monitor
        obs_t o;
        exp_t e;
        forever begin
            @(negedge clk);
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                checks++;
                if (o.act !== o.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", o.name, o.act, o.exp);
                end
            end
            if (rdata_valid === 1'b1 && prev_rv !== 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got rdata_out 0x%0h expected no response", rdata_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != 0 || rdata_out !== e.data) begin
                        errors++;
                        $display("FAIL resp_data: got kind 0 data 0x%0h expected kind %0d data 0x%0h", rdata_out, e.kind, e.data);
                    end
                end
            end
            if (addr_err === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL addr_err_unexpected: got pulse expected none");
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != 1) begin
                        errors++;
                        $display("FAIL addr_err_order: got kind 1 expected kind %0d", e.kind);
                    end
                end
            end
            prev_rv = rdata_valid;
            if (done && !finished) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
                end
                finished = 1'b1;
            end
        end
    end

    initial begin : global_watchdog
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        #1 rst = 1'b1;
        tick; tick;
        smp;
        obs("rst_req", 32'(data_sram_req), 32'd0);
        obs("rst_stall", 32'(stallreq_for_mem), 32'd0);
        obs("rst_rvalid", 32'(rdata_valid), 32'd0);
        obs("rst_rdata", rdata_out, 32'd0);
        obs("rst_timeout", 32'(timeout_err), 32'd0);
        obs("rst_addr", data_sram_addr, 32'd0);
        tick; rst = 1'b0; tick;

        // Word load, minimum latency
        do_load(32'h100, 32'hDEAD_BEEF, "ld100");
        obs("ld100_rdata_c3", rdata_out, 32'hDEAD_BEEF);
        tick; smp; obs("ld100_idle_rvalid", 32'(rdata_valid), 32'd0);
        tick;

        // Halfword store with addr_ok delayed three cycles
        expect_ev(0, 32'd0);
        issue(4'b1100, 2'd0, 32'h202, 32'hAABB_0000);
        smp; obs("st_stall_c0", 32'(stallreq_for_mem), 32'd1);
        tick; req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp;
            obs("st_hold_req", 32'(data_sram_req), 32'd1);
            obs("st_hold_wr", 32'(data_sram_wr), 32'd1);
            obs("st_hold_size", 32'(data_sram_size), 32'd1);
            obs("st_hold_wstrb", 32'(data_sram_wstrb), 32'hC);
            obs("st_hold_addr", data_sram_addr, 32'h202);
            obs("st_hold_wdata", data_sram_wdata, 32'hAABB_0000);
            tick;
        end
        data_sram_addr_ok = 1'b1;
        smp; obs("st_req_acc", 32'(data_sram_req), 32'd1);
        tick; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_5555;
        smp; obs("st_stall_data", 32'(stallreq_for_mem), 32'd1);
        tick; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
        smp; obs("st_done_rvalid", 32'(rdata_valid), 32'd1);
        tick; tick;

        // Flush in DATA, late data_ok dropped, new request stalled in DISCARD
        issue(4'b0000, 2'd2, 32'h400, 32'd0);
        tick; req_valid = 1'b0; data_sram_addr_ok = 1'b1;
        smp; obs("fl_req_c1", 32'(data_sram_req), 32'd1);
        tick; data_sram_addr_ok = 1'b0; flush = 1'b1;
        smp; obs("fl_stall_data", 32'(stallreq_for_mem), 32'd1);
        tick; flush = 1'b0;
        issue(4'b0000, 2'd2, 32'h500, 32'd0);
        smp; obs("fl_disc_stall", 32'(stallreq_for_mem), 32'd1);
        obs("fl_disc_req", 32'(data_sram_req), 32'd0);
        tick; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678;
        smp; obs("fl_disc_stall2", 32'(stallreq_for_mem), 32'd1);
        obs("fl_disc_rvalid", 32'(rdata_valid), 32'd0);
        tick; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
        expect_ev(0, 32'h0BAD_F00D);
        smp; obs("fl_idle_stall", 32'(stallreq_for_mem), 32'd1);
        obs("fl_idle_rvalid", 32'(rdata_valid), 32'd0);
        tick; req_valid = 1'b0; data_sram_addr_ok = 1'b1;
        smp; obs("fl_new_req", 32'(data_sram_req), 32'd1);
        obs("fl_new_addr", data_sram_addr, 32'h500);
        tick; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_F00D;
        tick; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
        smp; obs("fl_new_rvalid", 32'(rdata_valid), 32'd1);
        tick; tick;

        // Flush in ADDR without addr_ok
        issue(4'b0000, 2'd2, 32'h600, 32'd0);
        tick; req_valid = 1'b0; flush = 1'b1;
        smp; obs("fa_req_c1", 32'(data_sram_req), 32'd1);
        tick; flush = 1'b0;
        smp; obs("fa_req_c2", 32'(data_sram_req), 32'd0);
        obs("fa_stall_c2", 32'(stallreq_for_mem), 32'd0);
        tick; tick;

        // DONE held by stall_hold for four cycles
        do_load(32'h300, 32'hCAFE_F00D, "hold");
        stall_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick; smp;
            obs("hold_rvalid", 32'(rdata_valid), 32'd1);
            obs("hold_rdata", rdata_out, 32'hCAFE_F00D);
            obs("hold_stall", 32'(stallreq_for_mem), 32'd0);
            if (i == 3) stall_hold = 1'b0;
        end
        tick; smp; obs("hold_exit_rvalid", 32'(rdata_valid), 32'd0);
        tick;

        // Misaligned half load and irregular store strobes
        expect_ev(1, 32'd0);
        issue(4'b0000, 2'd1, 32'h101, 32'd0);
        smp; obs("mis_h_stall", 32'(stallreq_for_mem), 32'd0);
        tick; req_valid = 1'b0;
        smp; obs("mis_h_aerr", 32'(addr_err), 32'd1);
        obs("mis_h_req", 32'(data_sram_req), 32'd0);
        tick; smp; obs("mis_h_aerr_end", 32'(addr_err), 32'd0);
        tick;
        expect_ev(1, 32'd0);
        issue(4'b0101, 2'd0, 32'h000, 32'h1111_1111);
        smp; obs("mis_st_stall", 32'(stallreq_for_mem), 32'd0);
        tick; req_valid = 1'b0;
        smp; obs("mis_st_req", 32'(data_sram_req), 32'd0);
        tick; tick;

        // Watchdog: addr_ok never arrives
        issue(4'b0000, 2'd2, 32'h700, 32'd0);
        tick; req_valid = 1'b0;
        n_req = 0;
        for (int i = 0; i < 400; i++) begin
            smp;
            if (data_sram_req !== 1'b1) break;
            n_req++;
            tick;
        end
        obs("wd_req_cycles", 32'(n_req), 32'd255);
        obs("wd_timeout", 32'(timeout_err), 32'd1);
        obs("wd_stall", 32'(stallreq_for_mem), 32'd0);
        tick;
        do_load(32'h704, 32'h600D_CAFE, "post_wd");
        obs("wd_sticky", 32'(timeout_err), 32'd1);
        tick; tick;

        // Reset mid-transaction
        issue(4'b0000, 2'd2, 32'h800, 32'd0);
        tick; req_valid = 1'b0;
        smp; obs("mr_req_pre", 32'(data_sram_req), 32'd1);
        rst = 1'b1; #1;
        obs("mr_req_rst", 32'(data_sram_req), 32'd0);
        obs("mr_stall_rst", 32'(stallreq_for_mem), 32'd0);
        obs("mr_timeout_clr", 32'(timeout_err), 32'd0);
        tick; rst = 1'b0;
        tick; tick;

        done = 1'b1;
        for (int i = 0; i < 10 && !finished; i++) tick;
        if (!finished) begin
            $display("FAIL monitor_finish: got no drain expected drain");
            $fatal(1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
